// File: rtl/i2c_slave_if.sv
// I2C responder: oversamples SCL/SDA on clk, matches a 7-bit address, ACKs and
// moves bytes to/from core logic. SDA is open-drain; sda_oe=1 pulls the line low.
module i2c_slave_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] own_addr,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       rw,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_cond, stop_cond;

  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] rx_byte;
  logic [7:0] rx_data_nxt;
  logic       sda_oe_nxt, rw_nxt, busy_nxt;
  logic       rx_valid_nxt, tx_load_nxt, stop_det_nxt;

  // Synchronizer stage: presets to idle-bus level so reset release never looks like START
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev;
  assign scl_fall   = ~scl_s & scl_prev;
  assign start_cond = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_cond  = scl_s & scl_prev & ~sda_prev & sda_s;
  assign rx_byte    = {shreg[6:0], sda_s};

  // Protocol stage: next-state and output decode
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    sda_oe_nxt   = sda_oe;
    rw_nxt       = rw;
    busy_nxt     = busy;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    tx_load_nxt  = 1'b0;
    stop_det_nxt = 1'b0;

    case (state)
      ADDR: begin
        if (scl_rise) begin
          shreg_nxt   = rx_byte;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            rw_nxt = sda_s;
            if (shreg[6:0] != own_addr) begin
              state_nxt = IGNORE;
              busy_nxt  = 1'b0;
            end
          end
        end else if (scl_fall && bit_cnt == 4'd8) begin
          sda_oe_nxt  = 1'b1;
          busy_nxt    = 1'b1;
          bit_cnt_nxt = 4'd0;
          state_nxt   = ADDR_ACK;
        end
      end
      ADDR_ACK: begin
        if (scl_fall) begin
          bit_cnt_nxt = 4'd0;
          if (rw) begin
            shreg_nxt   = tx_data;
            tx_load_nxt = 1'b1;
            sda_oe_nxt  = ~tx_data[7];
            state_nxt   = RD_DATA;
          end else begin
            sda_oe_nxt = 1'b0;
            state_nxt  = WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (scl_rise) begin
          shreg_nxt   = rx_byte;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            rx_data_nxt  = rx_byte;
            rx_valid_nxt = 1'b1;
          end
        end else if (scl_fall && bit_cnt == 4'd8) begin
          sda_oe_nxt  = 1'b1;
          bit_cnt_nxt = 4'd0;
          state_nxt   = WR_ACK;
        end
      end
      WR_ACK: begin
        if (scl_fall) begin
          sda_oe_nxt = 1'b0;
          state_nxt  = WR_DATA;
        end
      end
      RD_DATA: begin
        // bit7 went out on entry, so seven more falls present bits 6..0 and the eighth releases
        if (scl_fall) begin
          if (bit_cnt == 4'd7) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 4'd0;
            state_nxt   = RD_ACK;
          end else begin
            shreg_nxt   = {shreg[6:0], 1'b0};
            sda_oe_nxt  = ~shreg[6];
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end
      RD_ACK: begin
        // A NACK leaves on the rise, so reaching the fall here means the master ACKed
        if (scl_rise && sda_s) begin
          state_nxt = IGNORE;
        end else if (scl_fall) begin
          shreg_nxt   = tx_data;
          tx_load_nxt = 1'b1;
          sda_oe_nxt  = ~tx_data[7];
          bit_cnt_nxt = 4'd0;
          state_nxt   = RD_DATA;
        end
      end
      IGNORE:  sda_oe_nxt = 1'b0;
      IDLE:    sda_oe_nxt = 1'b0;
      default: state_nxt = IDLE;
    endcase

    if (start_cond) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
    end
    if (stop_cond) begin
      state_nxt    = IDLE;
      sda_oe_nxt   = 1'b0;
      busy_nxt     = 1'b0;
      stop_det_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      sda_oe   <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      stop_det <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      sda_oe   <= sda_oe_nxt;
      rw       <= rw_nxt;
      busy     <= busy_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      tx_load  <= tx_load_nxt;
      stop_det <= stop_det_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

endmodule

// File: tb/tb_i2c_slave_if.sv
// Directed bench for i2c_slave_if: a bit-banged I2C master on a wired-AND SDA,
// with queued expected bytes compared as the slave delivers or returns them.
module tb_i2c_slave_if;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] own_addr = 7'b1110000;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe, rx_valid, tx_load, rw, busy, stop_det;
  logic [7:0] rx_data;
  logic       sda_bus;

  int vecs = 0;
  int fails = 0;

  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_obs[$];
  int         rx_rd = 0;

  int   rx_cnt = 0, txl_cnt = 0, stop_cnt = 0, oe_cnt = 0, busy_fall = 0, oe_hi_viol = 0;
  logic oe_prev = 1'b0, busy_prev = 1'b0;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_if #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .own_addr (own_addr),
    .scl      (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rw       (rw),
    .busy     (busy),
    .stop_det (stop_det)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_obs.push_back(rx_data);
    end
    if (tx_load) txl_cnt++;
    if (stop_det) stop_cnt++;
    if (sda_oe) oe_cnt++;
    if (busy_prev && !busy) busy_fall++;
    if (sda_oe && !oe_prev && scl_m) oe_hi_viol++;
    oe_prev   = sda_oe;
    busy_prev = busy;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic hq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hq();
    scl_m = 1'b1; hq();
    sda_m = 1'b0; hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hq();
    scl_m = 1'b1; hq();
    sda_m = 1'b1; hq();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; hq();
    scl_m = 1'b1; hq(); hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; hq();
    scl_m = 1'b1; hq();
    ack = ~sda_bus; hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; hq();
      scl_m = 1'b1; hq();
      b[i] = sda_bus; hq();
      scl_m = 1'b0; hq();
    end
    send_bit(nack);
  endtask

  task automatic sb_drain(input string tag);
    logic [7:0] e;
    while (rx_exp.size() > 0) begin
      e = rx_exp.pop_front();
      check({tag, "_rx_present"}, 32'(rx_rd < rx_obs.size()), 1);
      if (rx_rd < rx_obs.size()) begin
        check({tag, "_rx_data"}, 32'(rx_obs[rx_rd]), 32'(e));
        rx_rd++;
      end
    end
    check({tag, "_rx_extra"}, 32'(rx_obs.size() - rx_rd), 0);
  endtask

  task automatic sb_read(input string tag, input logic [7:0] got);
    logic [7:0] e;
    check({tag, "_tx_queued"}, 32'(tx_exp.size() > 0), 1);
    if (tx_exp.size() > 0) begin
      e = tx_exp.pop_front();
      check({tag, "_rd_byte"}, 32'(got), 32'(e));
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb, pat;
    int s_rx, s_txl, s_stop, s_oe, s_bf;

    repeat (3) @(negedge clk);
    check("rst_sda_oe",   32'(sda_oe),   0);
    check("rst_rx_data",  32'(rx_data),  0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_tx_load",  32'(tx_load),  0);
    check("rst_rw",       32'(rw),       0);
    check("rst_busy",     32'(busy),     0);
    check("rst_stop_det", 32'(stop_det), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // reset asserted while the address ACK is being held
    i2c_start();
    pat = 8'hE0;
    for (int i = 7; i >= 0; i--) send_bit(pat[i]);
    sda_m = 1'b1; hq();
    scl_m = 1'b1; hq();
    check("rstmid_oe_before", 32'(sda_oe), 1);
    reset = 1'b0;
    #1;
    check("rstmid_oe_async", 32'(sda_oe), 0);
    check("rstmid_busy",     32'(busy),   0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    hq();
    scl_m = 1'b0; hq();
    i2c_stop(); hq();

    // write E0, B2
    s_rx = rx_cnt; s_stop = stop_cnt; s_bf = busy_fall;
    i2c_start();
    write_byte(8'hE0, ack);
    check("wr_addr_ack", 32'(ack), 1);
    check("wr_rw",       32'(rw),  0);
    check("wr_busy",     32'(busy), 1);
    rx_exp.push_back(8'hB2);
    write_byte(8'hB2, ack);
    check("wr_data_ack",    32'(ack),  1);
    check("wr_busy_held",   32'(busy), 1);
    check("wr_no_stop_yet", stop_cnt - s_stop, 0);
    i2c_stop(); hq();
    check("wr_rx_pulses",   rx_cnt - s_rx, 1);
    sb_drain("wr");
    check("wr_busy_after",  32'(busy), 0);
    check("wr_stop_pulses", stop_cnt - s_stop, 1);
    check("wr_busy_falls",  busy_fall - s_bf, 1);

    // address mismatch
    s_rx = rx_cnt; s_stop = stop_cnt; s_oe = oe_cnt; s_bf = busy_fall;
    i2c_start();
    write_byte(8'hA0, ack);
    check("mm_addr_nack", 32'(ack), 0);
    write_byte(8'h55, ack);
    check("mm_data_nack", 32'(ack), 0);
    check("mm_busy",      32'(busy), 0);
    i2c_stop(); hq();
    check("mm_oe_cycles",   oe_cnt - s_oe, 0);
    check("mm_rx_pulses",   rx_cnt - s_rx, 0);
    check("mm_busy_falls",  busy_fall - s_bf, 0);
    check("mm_stop_pulses", stop_cnt - s_stop, 1);
    sb_drain("mm");

    // read 3C (ACK) then A5 (NACK)
    s_txl = txl_cnt; s_stop = stop_cnt;
    tx_data = 8'h3C; tx_exp.push_back(8'h3C);
    i2c_start();
    write_byte(8'hE1, ack);
    check("rd_addr_ack", 32'(ack), 1);
    check("rd_rw",       32'(rw),  1);
    tx_data = 8'hA5; tx_exp.push_back(8'hA5);
    read_byte(1'b0, rb);
    sb_read("rd1", rb);
    read_byte(1'b1, rb);
    sb_read("rd2", rb);
    s_oe = oe_cnt;
    hq(); hq();
    i2c_stop(); hq();
    check("rd_oe_after_nack", oe_cnt - s_oe, 0);
    check("rd_tx_loads",      txl_cnt - s_txl, 2);
    check("rd_busy_after",    32'(busy), 0);
    check("rd_stop_pulses",   stop_cnt - s_stop, 1);

    // repeated START: write 01, Sr, read one byte NACK
    s_bf = busy_fall; s_stop = stop_cnt;
    i2c_start();
    write_byte(8'hE0, ack);
    check("sr_addr1_ack", 32'(ack), 1);
    check("sr_rw_first",  32'(rw),  0);
    rx_exp.push_back(8'h01);
    write_byte(8'h01, ack);
    check("sr_data_ack", 32'(ack), 1);
    tx_data = 8'h5A; tx_exp.push_back(8'h5A);
    i2c_start();
    write_byte(8'hE1, ack);
    check("sr_addr2_ack", 32'(ack), 1);
    check("sr_rw_second", 32'(rw),  1);
    read_byte(1'b1, rb);
    sb_read("sr", rb);
    check("sr_busy_continuous", busy_fall - s_bf, 0);
    i2c_stop(); hq();
    sb_drain("sr");
    check("sr_busy_falls",  busy_fall - s_bf, 1);
    check("sr_stop_pulses", stop_cnt - s_stop, 1);
    check("sr_rx_data",     32'(rx_data), 32'h01);

    // START inside a write byte after four bits
    s_rx = rx_cnt;
    i2c_start();
    write_byte(8'hE0, ack);
    check("ab_addr1_ack", 32'(ack), 1);
    pat = 8'hB2;
    for (int i = 7; i >= 4; i--) send_bit(pat[i]);
    i2c_start();
    write_byte(8'hE0, ack);
    check("ab_addr2_ack",   32'(ack), 1);
    check("ab_rx_pulses",   rx_cnt - s_rx, 0);
    i2c_stop(); hq();
    sb_drain("ab");

    check("oe_rise_scl_high", oe_hi_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/i2c_slave_if.md
Name: i2c_slave_if

Overview:
- I2C responder (slave) for the tag's register/data interface; the other end of the I2C master in the same test chain.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address and ACKs. For writes, it delivers received bytes to core logic. For reads, it shifts out bytes supplied by core logic.
- SDA is open-drain: the block only ever pulls low.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on scl and sda_in (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- own_addr  input  7  slave address, sampled at each address-byte compare.
- scl  input  1  I2C clock from bus (slave never stretches).
- sda_in  input  1  I2C data as seen on bus.
- sda_oe  output  1  1 = pull SDA low, 0 = release.
- rx_data  output  8  last received write byte.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- tx_data  input  8  byte to return on read.
- tx_load  output  1  one-clk pulse when tx_data is captured into the shift register.
- rw  output  1  R/W bit of the current transaction (1 = read).
- busy  output  1  high from matched address until STOP or a non-matching restart.
- stop_det  output  1  one-clk pulse on detected STOP.

Behaviour:
- Reset (async assert, sync deassert):
  - sda_oe=0, rx_data=0, rx_valid=0, tx_load=0, rw=0, busy=0, stop_det=0.
  - State is IDLE and synchronizers are preset to 1.
- Conditions, evaluated on synchronized signals, one clk after sync:
  - START = sda falls while scl is high.
  - STOP = sda rises while scl is high.
  - Data is sampled on the synchronized scl rising edge.
  - sda_oe changes only on the synchronized scl falling edge.
- START or repeated START from any state:
  - Release sda_oe, clear the bit counter, go to ADDR.
  - This applies even mid-byte or mid-ACK.
- STOP from any state:
  - Go to IDLE, release sda_oe, busy=0, pulse stop_det.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits MSB first. On the 8th rising edge, compare bits[7:1] with own_addr and latch rw=bit0.
    - Match: on the next scl fall, sda_oe=1, busy=1, go to ADDR_ACK.
    - Mismatch: go to IGNORE.
  - ADDR_ACK: hold sda_oe=1 through the 9th clock high.
    - On the scl fall, if rw=0 release and go to WR_DATA.
    - If rw=1, capture tx_data, pulse tx_load, drive bit7 (sda_oe=~bit), go to RD_DATA.
  - WR_DATA: shift 8 bits.
    - On the 8th rising edge, update rx_data and pulse rx_valid in the same cycle.
    - On the next fall, sda_oe=1, go to WR_ACK. Every write byte is ACKed.
  - WR_ACK: on the scl fall, release and go to WR_DATA.
  - RD_DATA: on each scl fall, present the next bit.
    - After the 8th bit's fall, release sda_oe and go to RD_ACK.
  - RD_ACK: sample SDA on the scl rise.
    - 0 (ACK): on the fall, capture tx_data, pulse tx_load, drive bit7, go to RD_DATA.
    - 1 (NACK): go to IGNORE with sda_oe=0.
  - IGNORE: sda_oe=0 permanently; wait for START or STOP.
- Bit counter is 4 bits, 0..8, and resets at each byte boundary.
- The General-call address (0000000) is treated as an ordinary address (no special handling).
- The slave never drives SDA high. It never drives while scl is high, except to hold an ACK or data bit already set.
- Glitches shorter than SYNC_STAGES clks are not filtered beyond the synchronizer.

Test Plan:
- Reset mid-transfer: assert reset=0 while sda_oe=1 during ADDR_ACK -> sda_oe=0 and state IDLE immediately (async). After release, a new START works normally.
- Write, own_addr=7'b1110000: START, 0xE0, 0xB2, STOP ->
  - ACK (sda_oe=1) in both 9th clocks.
  - rx_data=8'hB2 with a single rx_valid pulse.
  - rw=0; busy high until stop_det.
- Address mismatch: START, 0xA0, 0x55, STOP ->
  - sda_oe never asserted, no rx_valid, busy stays 0.
  - stop_det pulses once.
- Read: START, 0xE1, tx_data=8'h3C, master ACKs the first byte and NACKs the second (tx_data=8'hA5) ->
  - SDA carries 0x3C then 0xA5.
  - tx_load pulses twice.
  - After the NACK, sda_oe=0 until STOP.
- Repeated START: START, 0xE0, 0x01, Sr, 0xE1, read one byte NACK, STOP ->
  - rx_data=8'h01.
  - rw changes 0->1 at the second address.
  - busy is continuous until stop_det.
- START inside a data byte: abort after 4 bits of a write byte with START+0xE0 ->
  - No rx_valid for the partial byte.
  - The new address is ACKed.
